// File: rtl/axis_pkt_arbiter_if.sv
// AXI-Stream bundle for the packet arbiter: N_SRC source lanes in, one
// tagged sink lane out. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives the sources and sink.
interface axis_pkt_arbiter_if #(
    parameter int N_SRC = 2,
    parameter int ID_W  = (N_SRC > 2) ? $clog2(N_SRC) : 1
);
    logic [N_SRC*32-1:0] s_tdata;
    logic [N_SRC*4-1:0]  s_tstrb;
    logic [N_SRC-1:0]    s_tlast;
    logic [N_SRC-1:0]    s_tvalid;
    logic [N_SRC-1:0]    s_tready;

    logic [31:0]         m_tdata;
    logic [3:0]          m_tstrb;
    logic                m_tlast;
    logic [ID_W-1:0]     m_tid;
    logic                m_tvalid;
    logic                m_tready;

    modport slave (
        input  s_tdata, s_tstrb, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tstrb, m_tlast, m_tid, m_tvalid
    );

    modport master (
        output s_tdata, s_tstrb, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tstrb, m_tlast, m_tid, m_tvalid
    );
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter. One source owns the sink from its
// first beat until its tlast beat is accepted, so packets never interleave.
// Each forwarded beat passes through a single output register and carries
// the index of the source that produced it on m_tid.
module axis_pkt_arbiter #(
    parameter int N_SRC = 2,
    parameter int ID_W  = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    axis_pkt_arbiter_if.slave  bus,
    output logic               busy,
    output logic [15:0]        pkt_count
);

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;

    logic                rr_hit;
    logic [ID_W-1:0]     rr_idx;

    logic                sel_valid;
    logic                sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic [STRB_W-1:0]   sel_strb;

    logic                out_free;
    logic                accept;
    logic [N_SRC-1:0]    ready;

    logic                vld_p1;
    logic [DATA_W-1:0]   data_p1;
    logic [STRB_W-1:0]   strb_p1;
    logic                last_p1;
    logic [ID_W-1:0]     tid_p1;

    // Round-robin search: first requester strictly after `last`, with wrap.
    // Walking the offsets from far to near lets the nearest hit win.
    function automatic logic [ID_W:0] rr_select(input logic [N_SRC-1:0] req,
                                                input logic [ID_W-1:0]  last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % N_SRC;
            if (req[ID_W'(idx)]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    // Arbitration candidate among all currently valid sources.
    always_comb begin
        {rr_hit, rr_idx} = rr_select(bus.s_tvalid, last_grant_q);
    end

    // Mux the granted source's lane onto the internal beat bus.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid = bus.s_tvalid[i];
                sel_last  = bus.s_tlast[i];
                sel_data  = bus.s_tdata[i*DATA_W +: DATA_W];
                sel_strb  = bus.s_tstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    always_comb begin
        out_free = !vld_p1 || bus.m_tready;
        accept   = (state_q == XFER) && out_free && sel_valid;
    end

    // Only the granted source sees ready, and only while a grant is held.
    always_comb begin
        ready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ready[i] = (state_q == XFER) && out_free && (grant_q == ID_W'(i));
        end
    end

    assign bus.s_tready = ready;
    assign busy         = (state_q == XFER);

    // Grant FSM next state: arbitrate in IDLE, hold the grant through XFER.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    grant_d = rr_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant FSM state register; last_grant starts at N_SRC-1 so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(N_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ---- stage p1: output register (load, or drain when sink takes the beat) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            strb_p1 <= '0;
            last_p1 <= 1'b0;
            tid_p1  <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= sel_data;
            strb_p1 <= sel_strb;
            last_p1 <= sel_last;
            tid_p1  <= grant_q;
        end else if (bus.m_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.m_tvalid = vld_p1;
    assign bus.m_tdata  = data_p1;
    assign bus.m_tstrb  = strb_p1;
    assign bus.m_tlast  = last_p1;
    assign bus.m_tid    = tid_p1;

    // Count packets as their tlast beat leaves the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= 16'd0;
        end else if (vld_p1 && bus.m_tready && last_p1) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter with two sources. A per-cycle
// reference model of the arbitration rules is checked against every DUT
// output; logs of accepted and forwarded beats pin the model with
// hand-computed literals for each scenario.
module tb_axis_pkt_arbiter;

    localparam int N    = 2;
    localparam int ID_W = 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        int          gap;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] pkt_count;

    axis_pkt_arbiter_if #(.N_SRC(N), .ID_W(ID_W)) bus();

    axis_pkt_arbiter #(.N_SRC(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source drivers
    beat_t srcq[N][$];
    int    wait_cnt[N];
    bit    loaded[N];
    logic [N-1:0] hs_q = '0;
    int    rdy_mode  = 0;
    bit    rdy_phase = 1'b0;

    // Observation logs
    int          log_tid[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_strb[$];
    bit          log_last[$];
    int          pkt_tid[$];
    int          acc_src[$];
    int          acc_cyc[$];
    int          hs_cnt[N];

    // Reference model state
    int          mo_owner = -1;
    int          mo_last  = N - 1;
    bit          mo_v     = 1'b0;
    logic [31:0] mo_d     = '0;
    logic [3:0]  mo_s     = '0;
    bit          mo_l     = 1'b0;
    int          mo_id    = 0;
    int          mo_cnt   = 0;

    task automatic push_beat(input int src, input logic [31:0] d, input logic [3:0] s,
                             input logic l, input int gap);
        beat_t b;
        b.data = d; b.strb = s; b.last = l; b.gap = gap;
        srcq[src].push_back(b);
    endtask

    task automatic update_sources();
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                loaded[i] = 1'b0;
            end
            if (srcq[i].size() > 0) begin
                if (!loaded[i]) begin
                    wait_cnt[i] = srcq[i][0].gap;
                    loaded[i]   = 1'b1;
                end else if (wait_cnt[i] > 0) begin
                    wait_cnt[i]--;
                end
            end
            if (srcq[i].size() > 0 && wait_cnt[i] == 0) begin
                bus.s_tvalid[i]         = 1'b1;
                bus.s_tdata[i*32 +: 32] = srcq[i][0].data;
                bus.s_tstrb[i*4 +: 4]   = srcq[i][0].strb;
                bus.s_tlast[i]          = srcq[i][0].last;
            end else begin
                bus.s_tvalid[i]         = 1'b0;
                bus.s_tdata[i*32 +: 32] = $urandom;
                bus.s_tstrb[i*4 +: 4]   = 4'($urandom);
                bus.s_tlast[i]          = 1'($urandom);
            end
        end
        if (rdy_mode == 1) begin
            rdy_phase     = ~rdy_phase;
            bus.m_tready  = rdy_phase;
        end else begin
            bus.m_tready  = 1'b1;
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            loaded[i]       = 1'b0;
            wait_cnt[i]     = 0;
            bus.s_tvalid[i] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        log_tid.delete(); log_data.delete(); log_strb.delete(); log_last.delete();
        pkt_tid.delete(); acc_src.delete(); acc_cyc.delete();
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        update_sources();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        step();
        step();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_src_left"}, 32'(srcq[0].size() + srcq[1].size()), 32'd0);
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    // Per-cycle compare against the model, observation logging, model advance
    initial begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] hs;
        bit           acc;
        int           j;
        forever begin
            @(negedge clk);
            cyc++;
            exp_rdy = '0;
            if (mo_owner >= 0 && (!mo_v || bus.m_tready)) exp_rdy[mo_owner] = 1'b1;
            chk("m_tvalid",  {31'd0, bus.m_tvalid}, {31'd0, mo_v});
            chk("m_tdata",   bus.m_tdata, mo_d);
            chk("m_tstrb",   {28'd0, bus.m_tstrb}, {28'd0, mo_s});
            chk("m_tlast",   {31'd0, bus.m_tlast}, {31'd0, mo_l});
            chk("m_tid",     {31'd0, bus.m_tid}, 32'(mo_id));
            chk("s_tready",  {30'd0, bus.s_tready}, {30'd0, exp_rdy});
            chk("busy",      {31'd0, busy}, {31'd0, (mo_owner >= 0)});
            chk("pkt_count", {16'd0, pkt_count}, 32'(mo_cnt));

            hs = bus.s_tvalid & bus.s_tready;
            hs_q = hs;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    hs_cnt[i]++;
                    acc_src.push_back(i);
                    acc_cyc.push_back(cyc);
                end
            end
            if (bus.m_tvalid && bus.m_tready) begin
                log_tid.push_back(int'(bus.m_tid));
                log_data.push_back(bus.m_tdata);
                log_strb.push_back(bus.m_tstrb);
                log_last.push_back(bus.m_tlast);
                if (bus.m_tlast) pkt_tid.push_back(int'(bus.m_tid));
            end

            if (rst) begin
                mo_owner = -1; mo_last = N - 1; mo_v = 1'b0; mo_d = '0;
                mo_s = '0; mo_l = 1'b0; mo_id = 0; mo_cnt = 0;
            end else begin
                acc = (mo_owner >= 0) && (!mo_v || bus.m_tready) && bus.s_tvalid[mo_owner];
                if (mo_v && bus.m_tready && mo_l) mo_cnt = (mo_cnt + 1) % 65536;
                if (acc) begin
                    mo_v  = 1'b1;
                    mo_d  = bus.s_tdata[mo_owner*32 +: 32];
                    mo_s  = bus.s_tstrb[mo_owner*4 +: 4];
                    mo_l  = bus.s_tlast[mo_owner];
                    mo_id = mo_owner;
                end else if (bus.m_tready) begin
                    mo_v = 1'b0;
                end
                if (mo_owner < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        j = (mo_last + k) % N;
                        if (mo_owner < 0 && bus.s_tvalid[j]) mo_owner = j;
                    end
                end else if (acc && mo_l) begin
                    mo_last  = mo_owner;
                    mo_owner = -1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tstrb  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        clear_sources();
        clear_logs();

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_m_tvalid",  {31'd0, bus.m_tvalid}, 32'd0);
        chk("rst_s_tready",  {30'd0, bus.s_tready}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);

        // 1: single 3-beat packet from source 0
        do_reset();
        push_beat(0, 32'h11111111, 4'hF, 1'b0, 0);
        push_beat(0, 32'h22222222, 4'hF, 1'b0, 0);
        push_beat(0, 32'h33333333, 4'hF, 1'b1, 0);
        run(15);
        chk("t1_nbeats", 32'(log_data.size()), 32'd3);
        chk("t1_d0", log_data[0], 32'h11111111);
        chk("t1_d1", log_data[1], 32'h22222222);
        chk("t1_d2", log_data[2], 32'h33333333);
        chk("t1_last0", {31'd0, log_last[0]}, 32'd0);
        chk("t1_last2", {31'd0, log_last[2]}, 32'd1);
        chk("t1_tid2", 32'(log_tid[2]), 32'd0);
        chk("t1_pkt_count", {16'd0, pkt_count}, 32'd1);
        chk_drained("t1");

        // 2: fairness, both sources offer two 2-beat packets
        do_reset();
        for (int p = 0; p < 2; p++) begin
            push_beat(0, 32'hA0000000 + 32'(p*2),     4'h3, 1'b0, 0);
            push_beat(0, 32'hA0000000 + 32'(p*2 + 1), 4'hC, 1'b1, 0);
            push_beat(1, 32'hB0000000 + 32'(p*2),     4'h1, 1'b0, 0);
            push_beat(1, 32'hB0000000 + 32'(p*2 + 1), 4'h8, 1'b1, 0);
        end
        run(25);
        chk("t2_npkts", 32'(pkt_tid.size()), 32'd4);
        chk("t2_order0", 32'(pkt_tid[0]), 32'd0);
        chk("t2_order1", 32'(pkt_tid[1]), 32'd1);
        chk("t2_order2", 32'(pkt_tid[2]), 32'd0);
        chk("t2_order3", 32'(pkt_tid[3]), 32'd1);
        chk("t2_strb1", {28'd0, log_strb[1]}, 32'hC);
        chk("t2_inpkt_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        chk("t2_interpkt_gap", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
        chk("t2_pkt_count", {16'd0, pkt_count}, 32'd4);
        chk_drained("t2");

        // 3: backpressure with m_tready alternating
        do_reset();
        rdy_mode = 1;
        for (int b = 0; b < 4; b++)
            push_beat(0, 32'hC0DE0000 + 32'(b), 4'h5, (b == 3), 0);
        run(20);
        rdy_mode = 0;
        step();
        chk("t3_nbeats", 32'(log_data.size()), 32'd4);
        for (int b = 0; b < 4; b++)
            chk("t3_data", log_data[b], 32'hC0DE0000 + 32'(b));
        chk("t3_pkt_count", {16'd0, pkt_count}, 32'd1);
        chk_drained("t3");

        // 4: granted source 1 stalls 5 cycles while source 0 waits
        do_reset();
        push_beat(1, 32'h10000001, 4'hF, 1'b0, 0);
        push_beat(1, 32'h10000002, 4'hF, 1'b0, 0);
        push_beat(1, 32'h10000003, 4'hF, 1'b0, 5);
        push_beat(1, 32'h10000004, 4'hF, 1'b1, 0);
        push_beat(0, 32'h00000001, 4'hF, 1'b0, 2);
        push_beat(0, 32'h00000002, 4'hF, 1'b1, 0);
        run(30);
        chk("t4_nacc", 32'(acc_src.size()), 32'd6);
        for (int k = 0; k < 4; k++) chk("t4_acc_src1", 32'(acc_src[k]), 32'd1);
        chk("t4_acc_src0a", 32'(acc_src[4]), 32'd0);
        chk("t4_acc_src0b", 32'(acc_src[5]), 32'd0);
        chk("t4_order0", 32'(pkt_tid[0]), 32'd1);
        chk("t4_order1", 32'(pkt_tid[1]), 32'd0);
        chk_drained("t4");

        // 5: sole source 1 with back-to-back single-beat packets
        do_reset();
        for (int b = 0; b < 4; b++)
            push_beat(1, 32'h50000000 + 32'(b), 4'h9, 1'b1, 0);
        run(15);
        chk("t5_npkts", 32'(pkt_tid.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("t5_tid", 32'(pkt_tid[k]), 32'd1);
        for (int k = 1; k < 4; k++) chk("t5_acc_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);
        chk("t5_pkt_count", {16'd0, pkt_count}, 32'd4);
        chk_drained("t5");

        // 6: reset during beat 2 of a 4-beat packet from source 1
        do_reset();
        for (int b = 0; b < 4; b++)
            push_beat(1, 32'h60000000 + 32'(b), 4'hF, (b == 3), 0);
        t = 0;
        while (hs_cnt[1] < 1 && t < 20) begin
            step();
            t++;
        end
        chk("t6_first_beat_in_time", {31'd0, (hs_cnt[1] >= 1)}, 32'd1);
        rst = 1'b1;
        clear_sources();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_m_tvalid",  {31'd0, bus.m_tvalid}, 32'd0);
        chk("t6_m_tdata",   bus.m_tdata, 32'd0);
        chk("t6_m_tlast",   {31'd0, bus.m_tlast}, 32'd0);
        chk("t6_m_tid",     {31'd0, bus.m_tid}, 32'd0);
        chk("t6_s_tready",  {30'd0, bus.s_tready}, 32'd0);
        chk("t6_busy",      {31'd0, busy}, 32'd0);
        chk("t6_pkt_count", {16'd0, pkt_count}, 32'd0);
        clear_logs();
        push_beat(0, 32'h70000000, 4'hF, 1'b1, 0);
        push_beat(1, 32'h71000000, 4'hF, 1'b1, 0);
        run(10);
        chk("t6_npkts", 32'(pkt_tid.size()), 32'd2);
        chk("t6_order0", 32'(pkt_tid[0]), 32'd0);
        chk("t6_order1", 32'(pkt_tid[1]), 32'd1);
        chk_drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
